// File: rtl/pic_inta_sequencer.sv
// 8259-style PIC service side: INT generation, 8086 two-pulse INTA handshake, ISR and EOI.
// Optional auto-EOI on the INTA#2 rise is compiled in with `define PIC_AUTO_EOI_EN.
module pic_inta_sequencer #(
  parameter int unsigned NUM_LEVELS   = 8,
  parameter logic [2:0]  SPURIOUS_LVL = 3'd7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_LEVELS-1:0] irr,
  input  logic                  inta_n,
  input  logic [4:0]            vector_base,
  input  logic                  eoi_valid,
  input  logic                  eoi_specific,
  input  logic [2:0]            eoi_level,
  input  logic                  aeoi,
  output logic                  int_out,
  output logic [NUM_LEVELS-1:0] isr,
  output logic [NUM_LEVELS-1:0] clear_irr,
  output logic                  freeze,
  output logic [7:0]            data_out,
  output logic                  data_oe
);

  typedef enum logic [1:0] {StIdle, StAck1, StGap, StAck2} state_e;

  localparam logic [NUM_LEVELS-1:0] OneLsb = {{(NUM_LEVELS-1){1'b0}}, 1'b1};

  state_e                state;
  logic                  inta_d;
  logic [2:0]            lvl;
  logic                  spurious;

  logic                  fall;
  logic                  rise;
  logic [2:0]            hp_req;
  logic [3:0]            hp_isr;
  logic                  req_wins;
  logic                  hold_int;
  logic                  int_next;
  logic                  ack1_start;
  logic [NUM_LEVELS-1:0] set_mask;
  logic [NUM_LEVELS-1:0] eoi_clr;
  logic [NUM_LEVELS-1:0] aeoi_clr;

  assign fall = inta_d & ~inta_n;
  assign rise = ~inta_d & inta_n;

  always_comb begin
    hp_req = 3'd0;
    for (int i = int'(NUM_LEVELS) - 1; i >= 0; i--) begin
      if (irr[i]) hp_req = 3'(i);
    end
  end

  // 8 encodes "nothing in service" so any request beats it.
  always_comb begin
    hp_isr = 4'd8;
    for (int i = int'(NUM_LEVELS) - 1; i >= 0; i--) begin
      if (isr[i]) hp_isr = 4'(i);
    end
  end

  assign req_wins   = (irr != '0) && ({1'b0, hp_req} < hp_isr);
  assign ack1_start = (state == StIdle) && fall;
  assign set_mask   = (ack1_start && (irr != '0)) ? (OneLsb << hp_req) : '0;

  always_comb begin
    if (state == StIdle) hold_int = fall;
    else                 hold_int = !((state == StAck2) && rise);
    int_next = hold_int ? 1'b1 : req_wins;
  end

  always_comb begin
    eoi_clr = '0;
    if (eoi_valid) begin
      if (eoi_specific)      eoi_clr[eoi_level]   = 1'b1;
      else if (isr != '0)    eoi_clr[hp_isr[2:0]] = 1'b1;
    end
  end

`ifdef PIC_AUTO_EOI_EN
  // A spurious acknowledge never set an ISR bit, so it must not retire one.
  assign aeoi_clr = (aeoi && (state == StAck2) && rise && !spurious) ? (OneLsb << lvl) : '0;
`else
  logic unused_aeoi;
  assign unused_aeoi = aeoi ^ spurious;
  assign aeoi_clr    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      inta_d    <= 1'b1;
      lvl       <= 3'd0;
      spurious  <= 1'b0;
      int_out   <= 1'b0;
      isr       <= '0;
      clear_irr <= '0;
      freeze    <= 1'b0;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
    end else begin
      inta_d    <= inta_n;
      int_out   <= int_next;
      // Clears first, then sets: a coincident EOI cannot kill the newly latched level.
      isr       <= (isr & ~eoi_clr & ~aeoi_clr) | set_mask;
      clear_irr <= set_mask;
      case (state)
        StIdle: begin
          if (fall) begin
            state    <= StAck1;
            lvl      <= (irr != '0) ? hp_req : SPURIOUS_LVL;
            spurious <= (irr == '0);
            freeze   <= 1'b1;
          end
        end
        StAck1: begin
          if (rise) state <= StGap;
        end
        StGap: begin
          if (fall) begin
            state    <= StAck2;
            data_out <= {vector_base, lvl};
            data_oe  <= 1'b1;
          end
        end
        StAck2: begin
          if (rise) begin
            state    <= StIdle;
            data_oe  <= 1'b0;
            freeze   <= 1'b0;
            data_out <= 8'h00;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Bench for pic_inta_sequencer: directed scenarios plus randomized INTA/EOI traffic
// checked against a transaction-level model of the ISR and priority rules.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] irr = 8'h00;
  logic       inta_n = 1'b1;
  logic [4:0] vector_base = 5'h00;
  logic       eoi_valid = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       aeoi = 1'b0;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clear_irr;
  logic       freeze;
  logic [7:0] data_out;
  logic       data_oe;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_isr = 8'h00;

`ifdef PIC_AUTO_EOI_EN
  localparam bit AutoEoi = 1'b1;
`else
  localparam bit AutoEoi = 1'b0;
`endif

  pic_inta_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irr          (irr),
    .inta_n       (inta_n),
    .vector_base  (vector_base),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .aeoi         (aeoi),
    .int_out      (int_out),
    .isr          (isr),
    .clear_irr    (clear_irr),
    .freeze       (freeze),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Index of the highest-priority (lowest) set bit; 8 when empty.
  function automatic int low(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic exp_int();
    return (irr != 8'h00) && (low(irr) < low(m_isr));
  endfunction

  task automatic model_eoi();
    if (eoi_specific) m_isr[eoi_level] = 1'b0;
    else              m_isr = m_isr & (m_isr - 8'h01);
  endtask

  task automatic do_eoi(input logic specific, input logic [2:0] level, input string tag);
    eoi_valid    = 1'b1;
    eoi_specific = specific;
    eoi_level    = level;
    model_eoi();
    tick();
    eoi_valid = 1'b0;
    check({tag, " isr"}, isr, m_isr);
  endtask

  // Full two-pulse acknowledge; the bench acts as the request register and drops the
  // acknowledged bit when clear_irr pulses. A pending eoi_valid lands on INTA#1.
  task automatic run_inta(input string tag);
    logic       spur;
    logic [2:0] lv;
    logic [7:0] oh;
    spur = (irr == 8'h00);
    lv   = spur ? 3'd7 : 3'(low(irr));
    oh   = spur ? 8'h00 : (8'h01 << lv);
    if (eoi_valid) model_eoi();
    m_isr  = m_isr | oh;
    inta_n = 1'b0;
    tick();
    eoi_valid = 1'b0;
    check({tag, " ack1 int_out"}, int_out, 1);
    check({tag, " ack1 freeze"}, freeze, 1);
    check({tag, " ack1 clear_irr"}, clear_irr, oh);
    check({tag, " ack1 isr"}, isr, m_isr);
    check({tag, " ack1 data_oe"}, data_oe, 0);
    irr = irr & ~oh;
    tick();
    check({tag, " clear pulse width"}, clear_irr, 0);
    inta_n = 1'b1;
    tick();
    check({tag, " gap data_oe"}, data_oe, 0);
    inta_n = 1'b0;
    tick();
    check({tag, " ack2 data_oe"}, data_oe, 1);
    check({tag, " ack2 data_out"}, data_out, {vector_base, lv});
    check({tag, " ack2 int_out"}, int_out, 1);
    inta_n = 1'b1;
    if (AutoEoi && aeoi) m_isr = m_isr & ~oh;
    tick();
    check({tag, " end data_oe"}, data_oe, 0);
    check({tag, " end data_out"}, data_out, 0);
    check({tag, " end freeze"}, freeze, 0);
    check({tag, " end isr"}, isr, m_isr);
    tick();
    check({tag, " end int_out"}, int_out, exp_int());
  endtask

  initial begin
    tick();
    check("reset int_out", int_out, 0);
    check("reset isr", isr, 0);
    check("reset clear_irr", clear_irr, 0);
    check("reset freeze", freeze, 0);
    check("reset data_oe", data_oe, 0);
    check("reset data_out", data_out, 0);
    rst_n = 1'b1;
    tick();

    // Basic acknowledge of level 2.
    irr = 8'h24;
    vector_base = 5'h11;
    tick();
    check("basic int_out", int_out, 1);
    run_inta("basic");
    check("basic isr", isr, 8'h04);

    // Nesting: lower priority blocked, higher priority accepted.
    irr = 8'h08;
    tick();
    tick();
    check("nest blocked int_out", int_out, 0);
    irr = 8'h01;
    tick();
    check("nest higher int_out", int_out, 1);
    run_inta("nest");
    check("nest isr", isr, 8'h05);

    // EOI forms.
    do_eoi(1'b0, 3'd0, "eoi nonspec");
    check("eoi nonspec value", isr, 8'h04);
    do_eoi(1'b1, 3'd2, "eoi spec");
    check("eoi spec value", isr, 8'h00);
    do_eoi(1'b0, 3'd0, "eoi empty");

    // Spurious: request withdrawn before INTA#1.
    irr = 8'h40;
    tick();
    check("spur int_out", int_out, 1);
    irr = 8'h00;
    vector_base = 5'h0a;
    run_inta("spur");

    // Reset in the middle of INTA#2 drops everything asynchronously.
    irr = 8'h02;
    tick();
    inta_n = 1'b0;
    tick();
    irr = 8'h00;
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check("pre-reset data_oe", data_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst data_oe", data_oe, 0);
    check("async rst isr", isr, 0);
    check("async rst int_out", int_out, 0);
    check("async rst freeze", freeze, 0);
    @(negedge clk);
    inta_n = 1'b1;
    m_isr  = 8'h00;
    rst_n  = 1'b1;
    tick();
    check("post-reset freeze", freeze, 0);

    // Auto-EOI request.
    irr  = 8'h10;
    aeoi = 1'b1;
    tick();
    run_inta("aeoi");
    check("aeoi isr", isr, AutoEoi ? 8'h00 : 8'h10);
    aeoi = 1'b0;

    // EOI coincident with INTA#1 on the same level keeps the new bit.
    irr = 8'h08;
    tick();
    eoi_valid = 1'b1;
    eoi_specific = 1'b1;
    eoi_level = 3'd3;
    run_inta("coinc");

    for (int n = 0; n < 40; n++) begin
      irr = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      vector_base = 5'($urandom);
      aeoi = 1'($urandom);
      tick();
      check("rand int_out", int_out, exp_int());
      if ($urandom_range(0, 3) == 0) begin
        eoi_valid = 1'b1;
        eoi_specific = 1'($urandom);
        eoi_level = 3'($urandom);
      end
      run_inta("rand");
      if ($urandom_range(0, 1) == 0) do_eoi(1'($urandom), 3'($urandom), "rand eoi");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
